// File: rtl/drum_map_pkg.sv
// drum_map_pkg: shared drum map for the drum voice trigger.
//   NUM_DRUMS    - number of mapped drums
//   drum_idx_t   - 3-bit drum index
//   DRUM_KEY     - HID keycode that fires each drum
//   DRUM_BASE    - sample ROM base address of each drum
//   DRUM_LEN     - sample length (in ticks) of each drum
//   key_to_drum  - keycode lookup, returns valid + drum index
package drum_map_pkg;

   localparam int unsigned NUM_DRUMS = 8;

   typedef logic [2:0] drum_idx_t;

   typedef struct packed {
      logic      valid;
      drum_idx_t idx;
   } drum_lookup_t;

   localparam logic [7:0] DRUM_KEY [NUM_DRUMS] = '{
      8'd43, 8'd20, 8'd26, 8'd8, 8'd21, 8'd23, 8'd28, 8'd24
   };

   localparam logic [19:0] DRUM_BASE [NUM_DRUMS] = '{
      20'h60EE0, 20'h68FB0, 20'h71130, 20'h79230,
      20'h81380, 20'h89470, 20'h915C0, 20'h996F8
   };

   localparam logic [15:0] DRUM_LEN [NUM_DRUMS] = '{
      16'h80D0, 16'h8180, 16'h8100, 16'h8150,
      16'h80F0, 16'h8150, 16'h8138, 16'h8000
   };

   // Keycode 0 (empty slot) never matches since no drum uses it.
   function automatic drum_lookup_t key_to_drum(input logic [7:0] key);
      drum_lookup_t res;
      res = '0;
      for (int i = 0; i < NUM_DRUMS; i++) begin
         if (key == DRUM_KEY[i]) begin
            res.valid = 1'b1;
            res.idx   = drum_idx_t'(i);
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/drum_voice_trigger_if.sv
// drum_voice_trigger_if: report input and per-voice playback outputs.
//   keycodes     - HID report, KEYS slots of KEY_W bits, 0 = empty
//   sample_tick  - one-cycle strobe per audio sample
//   voice_addr   - ROM address per voice (VOICES*ADDR_W)
//   voice_active - voice playing
//   voice_drum   - drum index per voice (VOICES*3)
//   voice_trig   - one-cycle pulse on voice (re)start
//   drop_pulse   - one-cycle pulse when a hit is discarded
// master: report source / sample consumer; slave: the trigger block.
interface drum_voice_trigger_if #(
   parameter int unsigned KEYS   = 6,
   parameter int unsigned KEY_W  = 8,
   parameter int unsigned VOICES = 4,
   parameter int unsigned ADDR_W = 20
);

   logic [KEYS*KEY_W-1:0]   keycodes;
   logic                    sample_tick;
   logic [VOICES*ADDR_W-1:0] voice_addr;
   logic [VOICES-1:0]       voice_active;
   logic [VOICES*3-1:0]     voice_drum;
   logic [VOICES-1:0]       voice_trig;
   logic                    drop_pulse;

   modport master (
      output keycodes, sample_tick,
      input  voice_addr, voice_active, voice_drum, voice_trig, drop_pulse
   );

   modport slave (
      input  keycodes, sample_tick,
      output voice_addr, voice_active, voice_drum, voice_trig, drop_pulse
   );

endinterface

// File: rtl/drum_voice.sv
// drum_voice: one playback voice. A load starts the sample at load_base for
// load_len ticks; each tick while playing advances the address until the last
// sample, after which the voice goes idle and the address holds.
//   clk, rst_n  - clock, asynchronous active-low reset
//   load        - start/restart with load_base/load_len/load_drum
//   tick        - audio sample strobe
//   addr        - current ROM address
//   active      - voice playing
//   drum        - drum index last loaded
//   trig        - one-cycle pulse after a load
module drum_voice
   import drum_map_pkg::*;
#(
   parameter int unsigned ADDR_W = 20,
   parameter int unsigned LEN_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              tick,
   input  logic [ADDR_W-1:0] load_base,
   input  logic [LEN_W-1:0]  load_len,
   input  drum_idx_t         load_drum,
   output logic [ADDR_W-1:0] addr,
   output logic              active,
   output drum_idx_t         drum,
   output logic              trig
);

   typedef enum logic [0:0] {StIdle, StPlay} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  remain_q, remain_d;
   drum_idx_t         drum_q, drum_d;
   logic              trig_q, trig_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         addr_q   <= '0;
         remain_q <= '0;
         drum_q   <= '0;
         trig_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         remain_q <= remain_d;
         drum_q   <= drum_d;
         trig_q   <= trig_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      remain_d = remain_q;
      drum_d   = drum_q;
      trig_d   = 1'b0;
      case (state_q)
         StIdle: ;
         StPlay: begin
            if (tick) begin
               if (remain_q == LEN_W'(1)) begin
                  state_d = StIdle;
               end else begin
                  addr_d   = addr_q + 1'b1;
                  remain_d = remain_q - 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
      // A load overrides any tick in the same cycle.
      if (load) begin
         state_d  = StPlay;
         addr_d   = load_base;
         remain_d = load_len;
         drum_d   = load_drum;
         trig_d   = 1'b1;
      end
   end

   assign addr   = addr_q;
   assign active = (state_q == StPlay);
   assign drum   = drum_q;
   assign trig   = trig_q;

endmodule

// File: rtl/drum_voice_trigger.sv
// drum_voice_trigger: turns HID reports into one-shot drum hits and assigns
// each hit to a playback voice. New presses latch into a pending mask; one
// pending drum (lowest index) is serviced per cycle and loaded into a voice:
// the voice already playing that drum, else the lowest idle voice, else the
// full-voice policy.
// Build option: DRUM_VOICE_STEAL_EN - when defined, a hit with all voices busy
// steals the voice at a round-robin pointer; otherwise the hit is dropped and
// drop_pulse fires.
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - drum_voice_trigger_if slave (report in, voice state out)
module drum_voice_trigger
   import drum_map_pkg::*;
#(
   parameter int unsigned KEYS   = 6,
   parameter int unsigned KEY_W  = 8,
   parameter int unsigned VOICES = 4,
   parameter int unsigned ADDR_W = 20,
   parameter int unsigned LEN_W  = 16
) (
   input logic                 clk,
   input logic                 rst_n,
   drum_voice_trigger_if.slave bus
);

   localparam int unsigned VidxW = (VOICES > 1) ? $clog2(VOICES) : 1;

   logic [KEYS*KEY_W-1:0] prev_keys_q;
   logic [NUM_DRUMS-1:0]  now_mask, prev_mask, new_press;
   logic [NUM_DRUMS-1:0]  pending_q, pending_d, srv_clr;
   drum_lookup_t          lk_now, lk_prev;

   logic                  srv_valid;
   drum_idx_t             srv_drum;
   logic [ADDR_W-1:0]     srv_base;
   logic [LEN_W-1:0]      srv_len;

   logic                  hit_found, idle_found;
   logic [VidxW-1:0]      hit_idx, idle_idx;
   logic [VOICES-1:0]     load;
   logic                  drop, drop_q;

   logic [VOICES-1:0]     voice_active_int;
   logic [VOICES-1:0]     voice_trig_int;
   drum_idx_t             voice_drum_int [VOICES];
   logic [ADDR_W-1:0]     voice_addr_int [VOICES];

`ifdef DRUM_VOICE_STEAL_EN
   localparam int unsigned PtrW = VidxW;
   logic [PtrW-1:0] steal_ptr_q, steal_ptr_d;
`endif

   // Drum presence in this report vs. last; duplicate slots fold into one bit.
   always_comb begin
      now_mask  = '0;
      prev_mask = '0;
      lk_now    = '0;
      lk_prev   = '0;
      for (int s = 0; s < KEYS; s++) begin
         lk_now  = key_to_drum(8'(bus.keycodes[s*KEY_W +: KEY_W]));
         lk_prev = key_to_drum(8'(prev_keys_q[s*KEY_W +: KEY_W]));
         if (lk_now.valid)  now_mask[lk_now.idx]   = 1'b1;
         if (lk_prev.valid) prev_mask[lk_prev.idx] = 1'b1;
      end
      new_press = now_mask & ~prev_mask;
   end

   // Lowest-index pending drum wins.
   always_comb begin
      srv_valid = 1'b0;
      srv_drum  = '0;
      for (int d = NUM_DRUMS - 1; d >= 0; d--) begin
         if (pending_q[d]) begin
            srv_valid = 1'b1;
            srv_drum  = drum_idx_t'(d);
         end
      end
      srv_base = ADDR_W'(DRUM_BASE[srv_drum]);
      srv_len  = LEN_W'(DRUM_LEN[srv_drum]);
      srv_clr  = '0;
      srv_clr[srv_drum] = srv_valid;
      // A fresh press of the serviced drum re-sets its bit.
      pending_d = (pending_q & ~srv_clr) | new_press;
   end

   // Voice allocation.
   always_comb begin
      hit_found  = 1'b0;
      hit_idx    = '0;
      idle_found = 1'b0;
      idle_idx   = '0;
      for (int v = VOICES - 1; v >= 0; v--) begin
         if (voice_active_int[v] && (voice_drum_int[v] == srv_drum)) begin
            hit_found = 1'b1;
            hit_idx   = VidxW'(v);
         end
         if (!voice_active_int[v]) begin
            idle_found = 1'b1;
            idle_idx   = VidxW'(v);
         end
      end
      load = '0;
      drop = 1'b0;
`ifdef DRUM_VOICE_STEAL_EN
      steal_ptr_d = steal_ptr_q;
`endif
      if (srv_valid) begin
         if (hit_found) begin
            load[hit_idx] = 1'b1;
         end else if (idle_found) begin
            load[idle_idx] = 1'b1;
         end else begin
`ifdef DRUM_VOICE_STEAL_EN
            load[steal_ptr_q] = 1'b1;
            if (steal_ptr_q == PtrW'(VOICES - 1)) steal_ptr_d = '0;
            else                                   steal_ptr_d = steal_ptr_q + 1'b1;
`else
            drop = 1'b1;
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_keys_q <= '0;
         pending_q   <= '0;
         drop_q      <= 1'b0;
      end else begin
         prev_keys_q <= bus.keycodes;
         pending_q   <= pending_d;
         drop_q      <= drop;
      end
   end

`ifdef DRUM_VOICE_STEAL_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) steal_ptr_q <= '0;
      else        steal_ptr_q <= steal_ptr_d;
   end
`endif

   for (genvar v = 0; v < VOICES; v++) begin : g_voice
      drum_voice #(
         .ADDR_W (ADDR_W),
         .LEN_W  (LEN_W)
      ) u_voice (
         .clk       (clk),
         .rst_n     (rst_n),
         .load      (load[v]),
         .tick      (bus.sample_tick),
         .load_base (srv_base),
         .load_len  (srv_len),
         .load_drum (srv_drum),
         .addr      (voice_addr_int[v]),
         .active    (voice_active_int[v]),
         .drum      (voice_drum_int[v]),
         .trig      (voice_trig_int[v])
      );
      assign bus.voice_addr[v*ADDR_W +: ADDR_W] = voice_addr_int[v];
      assign bus.voice_drum[v*3 +: 3]           = voice_drum_int[v];
   end

   assign bus.voice_active = voice_active_int;
   assign bus.voice_trig   = voice_trig_int;
   assign bus.drop_pulse   = drop_q;

endmodule

// File: doc/drum_voice_trigger.md
# drum_voice_trigger

Polyphonic drum trigger stage between the USB keyboard decoder and the sample-ROM readout. It turns a multi-key HID report into one-shot drum hits, maps each newly pressed key to a drum sample (base address and length), and assigns the hit to one of several playback voices. Each voice then walks its sample address once per audio sample tick until the sample ends.

## Interface
Parameters:
- KEYS, 6: keycode slots per HID report.
- KEY_W, 8: keycode width.
- VOICES, 4: playback voices (1..8).
- ADDR_W, 20: sample ROM address width.
- LEN_W, 16: sample length width.

Ports:
- clk  in  1: system clock.
- rst_n  in  1: asynchronous active-low reset.
- keycodes  in  KEYS*KEY_W: current report; slot i is bits [i*KEY_W +: KEY_W]; 0 means empty.
- sample_tick  in  1: one-cycle strobe per audio sample.
- voice_addr  out  VOICES*ADDR_W: current ROM address per voice.
- voice_active  out  VOICES: voice is playing.
- voice_drum  out  VOICES*3: drum index loaded in the voice.
- voice_trig  out  VOICES: one-cycle pulse when a voice is (re)started.
- drop_pulse  out  1: one-cycle pulse when a hit is discarded.

## Operation
- Drum map, 8 drums (index: keycode -> base, length):
  - 0: 43 -> 0x60EE0, 0x80D0
  - 1: 20 -> 0x68FB0, 0x8180
  - 2: 26 -> 0x71130, 0x8100
  - 3: 8 -> 0x79230, 0x8150
  - 4: 21 -> 0x81380, 0x80F0
  - 5: 23 -> 0x89470, 0x8150
  - 6: 28 -> 0x915C0, 0x8138
  - 7: 24 -> 0x996F8, 0x8000
- Other keycodes, including 0, are ignored.
- Press detection: a drum is newly pressed when its keycode appears in any slot of `keycodes` and in no slot of `prev_keys`. `prev_keys` is the previous cycle's report, registered. Duplicate slots count as one press.
- Pending mask (8 bits): newly pressed drums set their bit. Re-pressing a drum that is already pending merges into the existing bit.
- Arbiter: each cycle, service the lowest-index pending bit and clear it. If that drum also has a new press in the same cycle, the bit stays set.
- Voice selection for drum d, in priority order:
  1. A voice already holding d restarts (retrigger).
  2. Otherwise, the lowest-index idle voice.
  3. Otherwise, the steal policy (see Configuration).
- Voice FSM IDLE/PLAY:
  - Load: addr = base, remain = length, drum = d, state = PLAY, voice_trig = 1.
  - PLAY on sample_tick: if remain == 1, go to IDLE (addr holds); else addr+1 and remain-1.
  - Load and tick in the same cycle: load wins and the tick is ignored for that voice.
- Address arithmetic is ADDR_W bits with no wrap check; the map guarantees base+length < 2^ADDR_W.

## Timing
- Reset: all outputs 0; prev_keys, pending mask and steal pointer all 0.
- A keycode that is still held when reset is released counts as a new press in the first cycle after reset.
- Latency: report sampled at edge k sets the pending bit at edge k. The voice loads at edge k+1, so voice_active, voice_addr and voice_trig are visible after edge k+1.
- N simultaneous presses are serviced one per cycle, in ascending drum index, over N cycles.
- Holding a key produces no further hits. Release then press gives a new hit, minimum 2 cycles apart.
- All outputs are registered.
- Reset asserted mid-playback: every voice goes IDLE immediately and the pending mask clears.

## Configuration
- DRUM_VOICE_STEAL_EN defined: when all voices are busy, steal the voice at the round-robin steal pointer, then advance the pointer modulo VOICES. drop_pulse is never asserted.
- DRUM_VOICE_STEAL_EN undefined: when all voices are busy, discard the hit, clear its pending bit and pulse drop_pulse. The steal pointer is not implemented.

## Structure
- Package drum_map_pkg holds:
  - NUM_DRUMS = 8;
  - the drum_idx_t typedef (3 bits);
  - the keycode, base and length constant arrays;
  - the lookup function key_to_drum (returns valid + index).
- One sub-module, drum_voice: a single voice FSM with address/remain counters. It is instantiated VOICES times; allocation and arbitration stay in the top.

## Test plan
- Keycode 8 held 100 cycles, ticks every 4 cycles -> one voice_trig on voice 0; voice_addr 0x79230 then +1 per tick; voice_active high.
- Keycodes {43,20,26} in one report -> voice_trig on voices 0, 1, 2 in three consecutive cycles, drums 0, 1, 2.
- Kick playing, release then re-press 8 -> same voice retriggers; addr returns to 0x79230; no second voice used.
- Five distinct drums, VOICES=4: with macro, fifth steals voice 0; without macro, drop_pulse pulses once and voices are unchanged.
- Drum 7 runs 0x8000 ticks -> after the last tick voice_active = 0 and addr holds at 0x996F8+0x7FFF.
- rst_n low mid-playback with key 24 held -> outputs 0; after release, drum 7 triggers within 2 cycles.
